// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice and a carry flop, LSB first.
// SERIAL_ADDER_SUB_EN adds a sub input (a-b) and a signed-overflow output ovf.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             sub,
   output logic             ovf,
`endif
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
   logic             ovf_q, ovf_d;
`endif

   logic h1_s, h1_c, h2_c;
   logic sbit, nc;

   // Full-adder slice built from two half adders and a carry OR
   always_comb begin
      h1_s = a_q[0] ^ b_q[0];
      h1_c = a_q[0] & b_q[0];
      sbit = h1_s ^ carry_q;
      h2_c = h1_s & carry_q;
      nc   = h1_c | h2_c;
   end

   // Next-state and datapath control
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      r_d     = r_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
`ifdef SERIAL_ADDER_SUB_EN
               b_d     = sub ? ~b : b;
               carry_d = sub ? 1'b1 : cin;
`else
               b_d     = b;
               carry_d = cin;
`endif
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            r_d            = r_q >> 1;
            r_d[WIDTH-1]   = sbit;
            carry_d        = nc;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               state_d = DONE;
`ifdef SERIAL_ADDER_SUB_EN
               // carry into MSB vs carry out of MSB
               ovf_d   = carry_q ^ nc;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         r_q     <= r_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_SUB_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign ready = (state_q == IDLE);
   assign done  = (state_q == DONE);
   assign s     = r_q;
   assign c     = carry_q;
`ifdef SERIAL_ADDER_SUB_EN
   assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8 and WIDTH=1 instances).
// Random operands are checked against plain integer arithmetic.
module tb_serial_adder;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a_i = '0;
   logic [W-1:0] b_i = '0;
   logic         cin_i = 1'b0;
   logic         ready, done, c;
   logic [W-1:0] s;
`ifdef SERIAL_ADDER_SUB_EN
   logic         sub_i = 1'b0;
   logic         ovf;
   logic         sub1 = 1'b0;
   logic         ovf1;
`endif

   logic start1 = 1'b0;
   logic a1 = 1'b0;
   logic b1 = 1'b0;
   logic cin1 = 1'b0;
   logic ready1, done1, s1, c1;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a(a_i), .b(b_i), .cin(cin_i),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub_i), .ovf(ovf),
`endif
      .ready(ready), .done(done), .s(s), .c(c)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1),
      .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
      .sub(sub1), .ovf(ovf1),
`endif
      .ready(ready1), .done(done1), .s(s1), .c(c1)
   );

   // reference: {carry, sum} from integer arithmetic
   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sb);
      int r;
      if (sb) begin
         r = int'(x) - int'(y);
         return {(x >= y), W'(r)};
      end
      r = int'(x) + int'(y) + int'(ci);
      return (W+1)'(r);
   endfunction

   function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic ci, input logic sb);
      int sx, sy, r;
      sx = x[W-1] ? int'(x) - 256 : int'(x);
      sy = y[W-1] ? int'(y) - 256 : int'(y);
      r = sb ? sx - sy : sx + sy + int'(ci);
      return (r > 127) || (r < -128);
   endfunction

   // drive one operation; returns observed results and cycles to done (-1 on timeout)
   task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic sb, output logic [W-1:0] so, output logic co,
                        output logic vo, output int lat);
      @(negedge clk);
      for (int g = 0; g < 20 && !ready; g++) @(negedge clk);
      a_i = x;
      b_i = y;
      cin_i = ci;
`ifdef SERIAL_ADDER_SUB_EN
      sub_i = sb;
`endif
      start = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (i == 1) start = 1'b0;
         if (done) begin
            lat = i;
            break;
         end
      end
      so = s;
      co = c;
      vo = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      vo = ovf;
`else
      if (sb) vo = 1'b0;
`endif
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || done !== 1'b0 || s !== 8'h00 || c !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: ready=%b done=%b s=%h c=%b want 1 0 00 0", ready, done, s, c);
      end
`ifdef SERIAL_ADDER_SUB_EN
      n_checks++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ovf: ovf=%b want 0", ovf);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_directed();
      logic [W-1:0] xa [3] = '{8'h03, 8'hFF, 8'hFF};
      logic [W-1:0] xb [3] = '{8'h04, 8'h01, 8'h00};
      logic         xc [3] = '{1'b0, 1'b0, 1'b1};
      logic [W-1:0] es [3] = '{8'h07, 8'h00, 8'h00};
      logic         ec [3] = '{1'b0, 1'b1, 1'b1};
      logic [W-1:0] so;
      logic co, vo;
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(xa[i], xb[i], xc[i], 1'b0, so, co, vo, lat);
         n_checks++;
         if (lat != W + 1) begin
            n_fail++;
            $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, W + 1);
         end
         n_checks++;
         if (so !== es[i] || co !== ec[i]) begin
            n_fail++;
            $display("FAIL directed[%0d]: s=%h c=%b want s=%h c=%b", i, so, co, es[i], ec[i]);
         end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y, so;
      logic ci, sb, co, vo;
      logic [W:0] e;
      int lat;
      for (int i = 0; i < 24; i++) begin
         x = W'($urandom);
         y = W'($urandom);
         ci = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
         sb = 1'($urandom);
`else
         sb = 1'b0;
`endif
         do_op(x, y, ci, sb, so, co, vo, lat);
         e = ref_sum(x, y, ci, sb);
         n_checks++;
         if (lat != W + 1 || so !== e[W-1:0] || co !== e[W]) begin
            n_fail++;
            $display("FAIL random[%0d] %h,%h,%b,%b: lat=%0d s=%h c=%b want lat=%0d s=%h c=%b",
                     i, x, y, ci, sb, lat, so, co, W + 1, e[W-1:0], e[W]);
         end
`ifdef SERIAL_ADDER_SUB_EN
         n_checks++;
         if (vo !== ref_ovf(x, y, ci, sb)) begin
            n_fail++;
            $display("FAIL random_ovf[%0d]: ovf=%b want %b", i, vo, ref_ovf(x, y, ci, sb));
         end
`endif
      end
   endtask

   task automatic test_ignore_start();
      int lat;
      @(negedge clk);
      a_i = 8'h10;
      b_i = 8'h20;
      cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_i = 1'b0;
`endif
      start = 1'b1;
      @(posedge clk);
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         start = (i == 3);
         if (i == 3) a_i = 8'hAA;
         if (done) begin
            lat = i;
            break;
         end
      end
      start = 1'b0;
      n_checks++;
      if (lat != W + 1 || s !== 8'h30 || c !== 1'b0) begin
         n_fail++;
         $display("FAIL ignore_start: lat=%0d s=%h c=%b want lat=%0d s=30 c=0", lat, s, c, W + 1);
      end
      @(negedge clk);
      n_checks++;
      if (ready !== 1'b1 || done !== 1'b0) begin
         n_fail++;
         $display("FAIL ready_after_done: ready=%b done=%b want 1 0", ready, done);
      end
   endtask

   task automatic test_mid_reset();
      logic [W-1:0] so;
      logic co, vo;
      int lat;
      bit seen;
      @(negedge clk);
      a_i = 8'h55;
      b_i = 8'h55;
      cin_i = 1'b0;
      start = 1'b1;
      @(posedge clk);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (ready !== 1'b1 || done !== 1'b0 || s !== 8'h00 || c !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: ready=%b done=%b s=%h c=%b want 1 0 00 0", ready, done, s, c);
      end
      seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) seen = 1;
      end
      n_checks++;
      if (seen) begin
         n_fail++;
         $display("FAIL mid_reset_done: got done pulse want none");
      end
      do_op(8'h01, 8'h01, 1'b0, 1'b0, so, co, vo, lat);
      n_checks++;
      if (lat != W + 1 || so !== 8'h02 || co !== 1'b0) begin
         n_fail++;
         $display("FAIL after_reset: lat=%0d s=%h c=%b want %0d 02 0", lat, so, co, W + 1);
      end
   endtask

   task automatic test_back_to_back();
      int t1, t2;
      @(negedge clk);
      a_i = 8'h9C;
      b_i = 8'h71;
      cin_i = 1'b1;
      start = 1'b1;
      t1 = -1;
      t2 = -1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) begin
            n_checks++;
            if (s !== 8'h0E || c !== 1'b1) begin
               n_fail++;
               $display("FAIL back_to_back_sum: s=%h c=%b want 0e 1", s, c);
            end
            if (t1 < 0) t1 = i;
            else begin
               t2 = i;
               break;
            end
         end
      end
      start = 1'b0;
      n_checks++;
      if (t1 < 0 || t2 < 0 || t2 - t1 != W + 2) begin
         n_fail++;
         $display("FAIL back_to_back_gap: got %0d want %0d", t2 - t1, W + 2);
      end
   endtask

   task automatic test_width1();
      int lat;
      logic es, ec;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         a1 = k[0];
         b1 = k[1];
         cin1 = k[2];
         start1 = 1'b1;
         @(posedge clk);
         lat = -1;
         for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            start1 = 1'b0;
            if (done1) begin
               lat = i;
               break;
            end
         end
         es = 1'((k[0] + k[1] + k[2]) & 1);
         ec = (k[0] + k[1] + k[2]) >= 2;
         n_checks++;
         if (lat != 2 || s1 !== es || c1 !== ec) begin
            n_fail++;
            $display("FAIL width1[%0d]: lat=%0d s=%b c=%b want 2 %b %b", k, lat, s1, c1, es, ec);
         end
         @(negedge clk);
      end
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic test_sub();
      logic [W-1:0] xa [3] = '{8'h05, 8'h80, 8'h7F};
      logic [W-1:0] xb [3] = '{8'h07, 8'h01, 8'h01};
      logic         xs [3] = '{1'b1, 1'b1, 1'b0};
      logic [W-1:0] es [3] = '{8'hFE, 8'h7F, 8'h80};
      logic         ec [3] = '{1'b0, 1'b1, 1'b0};
      logic         ev [3] = '{1'b0, 1'b1, 1'b1};
      logic [W-1:0] so;
      logic co, vo;
      int lat;
      for (int i = 0; i < 3; i++) begin
         do_op(xa[i], xb[i], 1'b1 ^ xs[i], xs[i], so, co, vo, lat);
         if (!xs[i]) begin
            do_op(xa[i], xb[i], 1'b0, 1'b0, so, co, vo, lat);
         end
         n_checks++;
         if (so !== es[i] || co !== ec[i] || vo !== ev[i]) begin
            n_fail++;
            $display("FAIL sub[%0d]: s=%h c=%b ovf=%b want %h %b %b",
                     i, so, co, vo, es[i], ec[i], ev[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_mid_reset();
      test_random();
      test_back_to_back();
      test_width1();
`ifdef SERIAL_ADDER_SUB_EN
      test_sub();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
